// File: rtl/bin_erode_bbox_pkg.sv
// Shared constants and FSM state type for the erosion / bounding-box block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bin_erode_bbox_pkg;

    localparam int COORD_W = 11;
    localparam int CNT_W   = 21;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } bbox_state_t;

endpackage

// File: rtl/bin_erode_bbox_accum.sv
// Per-frame bounding box / pixel count accumulator with a report register set.
// Latency: accumulators registered; report lands 1 clk after frame_end is seen.
// Backpressure: none, consumes one pixel per clk unconditionally.
// Ports: x/y/pix_vld = current pixel; frame_start/frame_end = vsync edges;
//        box_* = report registers, box_valid pulses when they are loaded.
// Optional feature: BBOX_MIN_AREA_EN gates box_found on count >= MIN_AREA.
module bbox_accum
    import bin_erode_bbox_pkg::*;
#(
    parameter logic [CNT_W-1:0] MIN_AREA = 21'd16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               pix_vld,
    input  logic               frame_start,
    input  logic               frame_end,
    output logic               box_valid,
    output logic               box_found,
    output logic [COORD_W-1:0] box_xmin,
    output logic [COORD_W-1:0] box_xmax,
    output logic [COORD_W-1:0] box_ymin,
    output logic [COORD_W-1:0] box_ymax,
    output logic [CNT_W-1:0]   box_pix_cnt
);

    bbox_state_t state, state_nxt;
    logic acc_clr, acc_en, rpt_load;

    logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [CNT_W-1:0]   acc_cnt;
    logic               found_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        rpt_load  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                acc_en = pix_vld;
                if (frame_start) begin
                    // rise without a preceding fall: drop the partial frame
                    acc_clr = 1'b1;
                    acc_en  = 1'b0;
                end else if (frame_end) begin
                    rpt_load  = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
                if (frame_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // min registers start at all-ones so the first pixel always wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else if (acc_clr) begin
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else if (acc_en) begin
            if (x < acc_xmin) acc_xmin <= x;
            if (x > acc_xmax) acc_xmax <= x;
            if (y < acc_ymin) acc_ymin <= y;
            if (y > acc_ymax) acc_ymax <= y;
            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
        end
    end

`ifdef BBOX_MIN_AREA_EN
    assign found_w = (acc_cnt >= MIN_AREA);
`else
    assign found_w = (acc_cnt != '0);
`endif

    // report registers load on the edge entering REPORT, so box_valid and
    // the new values appear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_valid   <= 1'b0;
            box_found   <= 1'b0;
            box_xmin    <= '0;
            box_xmax    <= '0;
            box_ymin    <= '0;
            box_ymax    <= '0;
            box_pix_cnt <= '0;
        end else begin
            box_valid <= rpt_load;
            if (rpt_load) begin
                box_found   <= found_w;
                box_xmin    <= found_w ? acc_xmin : '0;
                box_xmax    <= found_w ? acc_xmax : '0;
                box_ymin    <= found_w ? acc_ymin : '0;
                box_ymax    <= found_w ? acc_ymax : '0;
                box_pix_cnt <= acc_cnt;
            end
        end
    end

endmodule

// File: rtl/bin_erode_bbox.sv
// Binary 3x3 erosion with border-aware taps plus per-frame target bounding box.
// Latency: video path 1 clk; box_valid 2 clk after matrix_img_vsync falls.
// Backpressure: none, streaming one pixel per clk.
// Ports: matrix_* = 3x3 window, edge flags and sync from the matrix generator;
//        post_img_* = eroded stream; box_* = once-per-frame target report.
// Optional feature: BBOX_MIN_AREA_EN (see bbox_accum).
module bin_erode_bbox
    import bin_erode_bbox_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP = 11'd640,
    parameter logic [COORD_W-1:0] IMG_VDISP = 11'd480,
    parameter logic [CNT_W-1:0]   MIN_AREA  = 21'd16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               matrix_img_vsync,
    input  logic               matrix_img_href,
    input  logic               matrix_top_edge_flag,
    input  logic               matrix_bottom_edge_flag,
    input  logic               matrix_left_edge_flag,
    input  logic               matrix_right_edge_flag,
    input  logic               matrix_p11,
    input  logic               matrix_p12,
    input  logic               matrix_p13,
    input  logic               matrix_p21,
    input  logic               matrix_p22,
    input  logic               matrix_p23,
    input  logic               matrix_p31,
    input  logic               matrix_p32,
    input  logic               matrix_p33,
    output logic               post_img_vsync,
    output logic               post_img_href,
    output logic               post_img_bit,
    output logic               box_valid,
    output logic               box_found,
    output logic [COORD_W-1:0] box_xmin,
    output logic [COORD_W-1:0] box_xmax,
    output logic [COORD_W-1:0] box_ymin,
    output logic [COORD_W-1:0] box_ymax,
    output logic [CNT_W-1:0]   box_pix_cnt
);

    logic top, bot, lft, rgt;
    logic erode_bit;

    assign top = matrix_top_edge_flag;
    assign bot = matrix_bottom_edge_flag;
    assign lft = matrix_left_edge_flag;
    assign rgt = matrix_right_edge_flag;

    // taps falling outside the image read as foreground
    assign erode_bit = matrix_img_href
                     & (matrix_p11 | top | lft) & (matrix_p12 | top) & (matrix_p13 | top | rgt)
                     & (matrix_p21 | lft)       &  matrix_p22        & (matrix_p23 | rgt)
                     & (matrix_p31 | bot | lft) & (matrix_p32 | bot) & (matrix_p33 | bot | rgt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_vsync <= 1'b0;
            post_img_href  <= 1'b0;
            post_img_bit   <= 1'b0;
        end else begin
            post_img_vsync <= matrix_img_vsync;
            post_img_href  <= matrix_img_href;
            post_img_bit   <= erode_bit;
        end
    end

    logic vs_d, hs_d, armed;
    logic frame_start, frame_end;
    logic [COORD_W-1:0] x_cnt, y_cnt;

    // armed only after vsync has been seen low since reset, so a reset
    // released mid-frame cannot start accumulating a partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            hs_d  <= 1'b0;
            armed <= 1'b0;
        end else begin
            vs_d  <= post_img_vsync;
            hs_d  <= post_img_href;
            armed <= armed | ~matrix_img_vsync;
        end
    end

    assign frame_start = armed & post_img_vsync & ~vs_d;
    assign frame_end   = ~post_img_vsync & vs_d;

    // x/y hold the coordinate of the pixel currently on post_img_*;
    // both stop at the frame size so a malformed stream cannot wrap them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (!post_img_href)          x_cnt <= '0;
            else if (x_cnt != IMG_HDISP) x_cnt <= x_cnt + 1'b1;

            if (!post_img_vsync)
                y_cnt <= '0;
            else if (hs_d && !post_img_href && y_cnt != IMG_VDISP)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    bbox_accum #(
        .MIN_AREA(MIN_AREA)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x_cnt),
        .y          (y_cnt),
        .pix_vld    (post_img_bit),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .box_valid  (box_valid),
        .box_found  (box_found),
        .box_xmin   (box_xmin),
        .box_xmax   (box_xmax),
        .box_ymin   (box_ymin),
        .box_ymax   (box_ymax),
        .box_pix_cnt(box_pix_cnt)
    );

endmodule
